uart_rgb_cmd_pwm: RTL
=====================

// Module: uart_rgb_cmd_pwm
// PURPOSE
//  Byte-stream command interpreter and multi-channel PWM generator for the board RGB LED.
//  Sits between the simpleuart byte interface and the SB_RGBA_DRV PWM inputs.
//  Accepts single-character preset commands and a 4-byte "set duty" command.
//  Returns one ACK/NAK/echo byte per command on a valid/ready TX handshake.
// PARAMETERS
//  NUM_CH       3       PWM channels; ch0=green, ch1=blue, ch2=red; range 1..8
//  PWM_BITS     8       duty resolution; range 1..8; takes the top PWM_BITS of the duty byte
//  PWM_DIV      47      hw_clk cycles per PWM count step, minus 1 (prescaler terminal value)
//  TIMEOUT_CYC  120000  idle hw_clk cycles allowed between bytes of a multi-byte command
// PORTS
//  hw_clk    in   1         system clock
//  rst       in   1         asynchronous reset, active-high
//  rx_valid  in   1         received byte available
//  rx_data   in   8         received byte
//  rx_ready  out  1         byte accepted when rx_valid && rx_ready
//  tx_valid  out  1         response byte pending
//  tx_data   out  8         response byte
//  tx_ready  in   1         UART takes the byte when tx_valid && tx_ready
//  pwm_out   out  NUM_CH    1 = LED channel on; feeds RGBnPWM
//  cmd_busy  out  1         parser is not in IDLE
// BEHAVIOUR
//  Reset state: all duties 0; pwm_out=0; tx_valid=0; tx_data=0; rx_ready=1; cmd_busy=0; FSM=IDLE.
//  FSM states are IDLE, GET_CH, GET_HI, GET_LO and RESP. rx_ready = (state != RESP).
//  IDLE:
//   - digit '0'..'0'+2^NUM_CH-1: preset. shadow[i] = bit i of value ? all-ones : 0. Response '.'.
//   - 'S': go to GET_CH. No response yet.
//   - any other byte b: response is the echo (b+1) mod 256.
//  GET_CH: digit < NUM_CH -> latch channel, go to GET_HI. Anything else -> NAK '?', return to IDLE.
//  GET_HI / GET_LO: hex digits 0-9, A-F, a-f. Invalid digit -> '?', return to IDLE.
//   - After a valid GET_LO: shadow[ch] = duty_byte[7 -: PWM_BITS]. Response '.'.
//  RESP: tx_valid=1 with tx_data held stable until the tx_ready handshake, then IDLE.
//   - tx_valid rises the cycle after the last command byte is accepted.
//   - While RESP, no byte is accepted (rx_ready=0); bytes are backpressured, never dropped.
//  Timeout: in GET_* with no byte for TIMEOUT_CYC cycles -> '?' response, return to IDLE.
//   - Timer clears on every accepted byte.
//  PWM:
//   - Prescaler counts 0..PWM_DIV.
//   - On prescaler terminal, cnt advances 0..2^PWM_BITS-2, then wraps to 0.
//   - pwm_out[i] = (cnt < active[i]): duty 0 is always off; all-ones is always on.
//   - shadow->active copy happens only on the cycle cnt wraps to 0, so there are no mid-period glitches.
//   - Period latency: a new duty takes effect within 1 PWM period.
//  Simultaneous: a shadow write on the wrap cycle takes effect at the next wrap (the copy uses the old shadow).
//  Reset mid-command or mid-response: everything returns to reset values immediately and the pending tx byte is discarded.
//  Width rules: all arithmetic is unsigned; echo addition is 8-bit and wraps (0xFF -> 0x00).
// STRUCTURE
//  Shared package: command character constants ('S', '.', '?'), FSM state enum, hex-decode function.
//  Sub-module: rgb_pwm_gen.
//   - Contents: prescaler, shared counter, NUM_CH shadow/active duty registers, comparators.
//   - Interface: wr_en, wr_ch, wr_duty.
//  Top level: parser FSM, timeout counter, TX holding register.
// TESTING
//  1 Reset mid-stream: assert rst during GET_HI.
//    -> all outputs at reset values; next 'S','0','F','F' works normally.
//  2 Preset: send '5', tx_ready=1.
//    -> tx '.' one cycle later; after wrap, active = {FF,00,FF}.
//    -> pwm_out[0], pwm_out[2] constant 1; pwm_out[1] constant 0.
//  3 Duty: send 'S','1','8','0'.
//    -> tx '.'; pwm_out[1] high exactly 128 of 255 counts per period.
//    -> each count lasts PWM_DIV+1 cycles.
//  4 Errors: send 'S','7' -> tx '?'. Send 'S','0','G' -> tx '?'.
//    Send 'x' -> tx 'y'. Send 0xFF -> tx 0x00.
//  5 Backpressure: hold tx_ready=0 after '3'.
//    -> tx_valid/tx_data '.' stable and rx_ready=0.
//    -> a following '0' is accepted only after tx_ready pulses.
//  6 Timeout: send 'S','2' then idle TIMEOUT_CYC cycles.
//    -> tx '?', cmd_busy=0, duty of ch2 unchanged.

Source files
------------

// File: rtl/uart_rgb_cmd_pwm_pkg.sv
// Shared definitions for the UART RGB command interpreter: command characters,
// parser states and the ASCII hex-digit decoder.
package uart_rgb_cmd_pwm_pkg;

    localparam logic [7:0] CHR_SET  = 8'h53;  // 'S'
    localparam logic [7:0] CHR_ACK  = 8'h2E;  // '.'
    localparam logic [7:0] CHR_NAK  = 8'h3F;  // '?'
    localparam logic [7:0] CHR_ZERO = 8'h30;  // '0'

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GET_CH = 3'd1,
        ST_GET_HI = 3'd2,
        ST_GET_LO = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    // Returns {valid, nibble}; accepts 0-9, A-F and a-f.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        r = 5'h00;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, c[3:0]};
        end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            r = {1'b1, c[3:0] + 4'd9};
        end else begin
            r = 5'h00;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rgb_cmd_pwm_rgb_pwm_gen.sv
// Multi-channel PWM: shared prescaler and counter, per-channel shadow/active duty
// registers with the shadow copied to active only when the counter wraps.
module rgb_pwm_gen #(
    parameter int NUM_CH   = 3,
    parameter int PWM_BITS = 8,
    parameter int PWM_DIV  = 47,
    parameter int CH_W     = 2
) (
    input  logic              hw_clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [7:0]        wr_duty,
    input  logic              ld_en,
    input  logic [NUM_CH-1:0] ld_mask,
    output logic [NUM_CH-1:0] pwm_out
);
    import uart_rgb_cmd_pwm_pkg::*;

    localparam int PRE_W = (PWM_DIV > 0) ? $clog2(PWM_DIV + 1) : 1;
    localparam logic [PRE_W-1:0]    PRE_MAX = PRE_W'(PWM_DIV);
    localparam logic [PWM_BITS-1:0] CNT_MAX = PWM_BITS'((2 ** PWM_BITS) - 2);

    logic [PRE_W-1:0]    pre_r;
    logic [PWM_BITS-1:0] cnt_r;
    logic [PWM_BITS-1:0] shadow_r [NUM_CH];
    logic [PWM_BITS-1:0] active_r [NUM_CH];
    logic [NUM_CH-1:0]   pwm_out_r;
    logic                wrap_s;

    assign wrap_s  = (pre_r == PRE_MAX) && (cnt_r == CNT_MAX);
    assign pwm_out = pwm_out_r;

    // Prescaler and shared PWM counter; the counter skips the all-ones value so a full duty stays on.
    always_ff @(posedge hw_clk or posedge rst) begin
        if (rst) begin
            pre_r <= '0;
            cnt_r <= '0;
        end else if (pre_r == PRE_MAX) begin
            pre_r <= '0;
            cnt_r <= (cnt_r == CNT_MAX) ? '0 : cnt_r + PWM_BITS'(1);
        end else begin
            pre_r <= pre_r + PRE_W'(1);
        end
    end

    // Duty registers, comparators; a write on the wrap cycle lands at the following wrap.
    always_ff @(posedge hw_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_r[i] <= '0;
                active_r[i] <= '0;
            end
            pwm_out_r <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ld_en) begin
                    shadow_r[i] <= ld_mask[i] ? '1 : '0;
                end else if (wr_en && (wr_ch == CH_W'(i))) begin
                    shadow_r[i] <= wr_duty[7 -: PWM_BITS];
                end
                if (wrap_s) begin
                    active_r[i] <= shadow_r[i];
                end
                pwm_out_r[i] <= (cnt_r < active_r[i]);
            end
        end
    end

endmodule

// File: rtl/uart_rgb_cmd_pwm.sv
// Byte-stream command parser for the board RGB LED: presets, 4-byte set-duty
// command, one response byte per command on a valid/ready TX handshake.
module uart_rgb_cmd_pwm #(
    parameter int NUM_CH      = 3,
    parameter int PWM_BITS    = 8,
    parameter int PWM_DIV     = 47,
    parameter int TIMEOUT_CYC = 120000
) (
    input  logic              hw_clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              cmd_busy
);
    import uart_rgb_cmd_pwm_pkg::*;

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_e          state_r, next_state_s;
    logic [CH_W-1:0] ch_r;
    logic [3:0]      hi_r;
    logic [7:0]      tx_data_r;
    logic [31:0]     timer_r;
    logic            accept_s, in_get_s, timeout_s, preset_ok_s, ch_ok_s;
    logic [7:0]      digit_s;
    logic [4:0]      hex_s;
    logic            tx_load_s, wr_en_s, ld_en_s, lat_ch_s, lat_hi_s;
    logic [7:0]      tx_byte_s;

    assign rx_ready    = (state_r != ST_RESP);
    assign tx_valid    = (state_r == ST_RESP);
    assign tx_data     = tx_data_r;
    assign cmd_busy    = (state_r != ST_IDLE);
    assign accept_s    = rx_valid && rx_ready;
    assign in_get_s    = (state_r == ST_GET_CH) || (state_r == ST_GET_HI) || (state_r == ST_GET_LO);
    assign timeout_s   = (timer_r == 32'(TIMEOUT_CYC - 1));
    assign digit_s     = rx_data - CHR_ZERO;
    assign hex_s       = hex_decode(rx_data);
    assign preset_ok_s = (rx_data >= CHR_ZERO) && ({24'd0, digit_s} < 32'(1 << NUM_CH));
    assign ch_ok_s     = (rx_data >= CHR_ZERO) && ({24'd0, digit_s} < 32'(NUM_CH));

    // Parser next-state and per-byte actions.
    always_comb begin
        next_state_s = state_r;
        tx_load_s    = 1'b0;
        tx_byte_s    = 8'h00;
        wr_en_s      = 1'b0;
        ld_en_s      = 1'b0;
        lat_ch_s     = 1'b0;
        lat_hi_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    next_state_s = ST_IDLE;
                end else if (preset_ok_s) begin
                    ld_en_s      = 1'b1;
                    tx_load_s    = 1'b1;
                    tx_byte_s    = CHR_ACK;
                    next_state_s = ST_RESP;
                end else if (rx_data == CHR_SET) begin
                    next_state_s = ST_GET_CH;
                end else begin
                    tx_load_s    = 1'b1;
                    tx_byte_s    = rx_data + 8'd1;
                    next_state_s = ST_RESP;
                end
            end
            ST_GET_CH, ST_GET_HI, ST_GET_LO: begin
                if (accept_s && (state_r == ST_GET_CH) && ch_ok_s) begin
                    lat_ch_s     = 1'b1;
                    next_state_s = ST_GET_HI;
                end else if (accept_s && (state_r == ST_GET_HI) && hex_s[4]) begin
                    lat_hi_s     = 1'b1;
                    next_state_s = ST_GET_LO;
                end else if (accept_s && (state_r == ST_GET_LO) && hex_s[4]) begin
                    wr_en_s      = 1'b1;
                    tx_load_s    = 1'b1;
                    tx_byte_s    = CHR_ACK;
                    next_state_s = ST_RESP;
                end else if (accept_s || timeout_s) begin
                    tx_load_s    = 1'b1;
                    tx_byte_s    = CHR_NAK;
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_RESP: begin
                if (tx_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Parser state register.
    always_ff @(posedge hw_clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Command operand latches, TX holding register and inter-byte timeout timer.
    always_ff @(posedge hw_clk or posedge rst) begin
        if (rst) begin
            ch_r      <= '0;
            hi_r      <= 4'h0;
            tx_data_r <= 8'h00;
            timer_r   <= 32'd0;
        end else begin
            if (lat_ch_s) begin
                ch_r <= digit_s[CH_W-1:0];
            end
            if (lat_hi_s) begin
                hi_r <= hex_s[3:0];
            end
            if (tx_load_s) begin
                tx_data_r <= tx_byte_s;
            end
            timer_r <= (in_get_s && !accept_s) ? timer_r + 32'd1 : 32'd0;
        end
    end

    rgb_pwm_gen #(
        .NUM_CH   (NUM_CH),
        .PWM_BITS (PWM_BITS),
        .PWM_DIV  (PWM_DIV),
        .CH_W     (CH_W)
    ) u_pwm (
        .hw_clk  (hw_clk),
        .rst     (rst),
        .wr_en   (wr_en_s),
        .wr_ch   (ch_r),
        .wr_duty ({hi_r, hex_s[3:0]}),
        .ld_en   (ld_en_s),
        .ld_mask (digit_s[NUM_CH-1:0]),
        .pwm_out (pwm_out)
    );

endmodule
